// File: rtl/rgb_p2p_tx_pkg.sv
// Shared filter-flow package: FSM state encodings and default pixel/length widths.
package rgb_p2p_tx_pkg;

  localparam int unsigned RGB_DATA_W = 24;
  localparam int unsigned RGB_LEN_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/rgb_sync_fifo.sv
// Single-clock pixel FIFO with occupancy counter; a push while full is dropped even if a pop
// happens in the same cycle.
module rgb_sync_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: flushing the pointers makes stale entries unreachable.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rgb_p2p_tx.sv
// Frame transmitter: queues upstream pixels and streams a counted frame over a valid/busy
// point-to-point link toward the DC filter.
module rgb_p2p_tx
  import rgb_p2p_tx_pkg::*;
#(
  parameter int unsigned DATA_W = RGB_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEN_W  = RGB_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_wr,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_full,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_frame_len,
  output logic              o_active,
  output logic              o_done,
  output logic              o_rgb_vld,
  output logic [DATA_W-1:0] o_rgb_data,
  input  logic              i_rgb_busy
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              xfer;

  rgb_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_pix_wr),
    .i_data  (i_pix_data),
    .i_pop   (xfer),
    .o_full  (o_pix_full),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

  // Valid and data depend only on state and FIFO registers, never on i_rgb_busy.
  assign o_rgb_vld  = (state_q == ST_SEND) && !fifo_empty;
  assign o_rgb_data = o_rgb_vld ? fifo_head : '0;
  assign o_active   = (state_q == ST_SEND);
  assign o_done     = (state_q == ST_DONE);
  assign xfer       = o_rgb_vld && !i_rgb_busy;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_frame_len != '0) begin
            remaining_d = i_frame_len;
            state_d     = ST_SEND;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_rgb_p2p_tx.sv
// Scoreboard bench for rgb_p2p_tx: stimulus queues expected pixels, a negedge monitor checks
// every presented pixel against the queue head and retires it on transfer.
module tb_rgb_p2p_tx;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_wr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_full;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic              active;
  logic              done;
  logic              rgb_vld;
  logic [DATA_W-1:0] rgb_data;
  logic              rgb_busy;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  rgb_p2p_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pix_wr    (pix_wr),
    .i_pix_data  (pix_data),
    .o_pix_full  (pix_full),
    .i_start     (start),
    .i_frame_len (frame_len),
    .o_active    (active),
    .o_done      (done),
    .o_rgb_vld   (rgb_vld),
    .o_rgb_data  (rgb_data),
    .i_rgb_busy  (rgb_busy)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle; vld && !busy here means a transfer at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rgb_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got %06h, expected nothing queued", rgb_data);
        end else begin
          if (rgb_data !== exp_q[0]) begin
            errors++;
            $display("FAIL pixel_data: got %06h, expected %06h", rgb_data, exp_q[0]);
          end
          if (!rgb_busy) void'(exp_q.pop_front());
        end
      end else if (!active) begin
        checks++;
        if (rgb_data !== '0) begin
          errors++;
          $display("FAIL idle_data_zero: got %06h, expected 000000", rgb_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_pix(input logic [DATA_W-1:0] d, input bit accepted);
    pix_wr   = 1'b1;
    pix_data = d;
    if (accepted) exp_q.push_back(d);
    tick();
    pix_wr   = 1'b0;
  endtask

  task automatic start_frame(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; pix_wr = 1'b0; pix_data = '0; start = 1'b0; frame_len = '0; rgb_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_vld",    {31'd0, rgb_vld},  32'd0);
    chk("reset_data",   {8'd0, rgb_data},  32'd0);
    chk("reset_full",   {31'd0, pix_full}, 32'd0);
    chk("reset_active", {31'd0, active},   32'd0);
    chk("reset_done",   {31'd0, done},     32'd0);

    // Preload three, frame of three, back-to-back transfers
    write_pix(24'h102030, 1);
    write_pix(24'h405060, 1);
    write_pix(24'h708090, 1);
    start_frame(16'd3);
    chk("f3_active", {31'd0, active},  32'd1);
    chk("f3_vld0",   {31'd0, rgb_vld}, 32'd1);
    tick();
    chk("f3_vld1",   {31'd0, rgb_vld}, 32'd1);
    tick();
    chk("f3_vld2",   {31'd0, rgb_vld}, 32'd1);
    tick();
    chk("f3_done",   {31'd0, done},    32'd1);
    chk("f3_vld_in_done", {31'd0, rgb_vld}, 32'd0);
    chk("f3_queue_empty", exp_q.size(), 32'd0);
    tick();
    chk("f3_done_one_cycle", {31'd0, done},   32'd0);
    chk("f3_back_idle",      {31'd0, active}, 32'd0);

    // Busy stall: data must hold for all five busy cycles
    write_pix(24'h102030, 1);
    write_pix(24'h405060, 1);
    rgb_busy = 1'b1;
    start_frame(16'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {8'd0, rgb_data}, 32'h102030);
      tick();
    end
    rgb_busy = 1'b0;
    tick();
    chk("stall_next_pixel", {8'd0, rgb_data}, 32'h405060);
    wait_done("stall_done", 10);
    tick();

    // Overfill in IDLE: fifth write dropped
    write_pix(24'h000001, 1);
    write_pix(24'h000002, 1);
    write_pix(24'h000003, 1);
    chk("fill_not_full_at3", {31'd0, pix_full}, 32'd0);
    write_pix(24'h000004, 1);
    chk("fill_full_at4", {31'd0, pix_full}, 32'd1);
    write_pix(24'h000005, 0);
    chk("fill_full_after5", {31'd0, pix_full}, 32'd1);
    start_frame(16'd4);
    wait_done("fill_done", 20);
    chk("fill_vld_after", {31'd0, rgb_vld}, 32'd0);
    chk("fill_full_after", {31'd0, pix_full}, 32'd0);
    tick();
    write_pix(24'h0000F6, 1);
    start_frame(16'd1);
    wait_done("fill_followup_done", 10);
    chk("fill_queue_empty", exp_q.size(), 32'd0);
    tick();

    // Zero-length frame
    start_frame(16'd0);
    chk("zero_done",   {31'd0, done},    32'd1);
    chk("zero_vld",    {31'd0, rgb_vld}, 32'd0);
    chk("zero_active", {31'd0, active},  32'd0);
    tick();
    chk("zero_back_idle", {31'd0, done}, 32'd0);

    // Reset mid-frame after two of four transfers; write/start during reset discarded
    write_pix(24'h111111, 1);
    write_pix(24'h222222, 1);
    write_pix(24'h333333, 1);
    write_pix(24'h444444, 1);
    start_frame(16'd4);
    tick();
    tick();
    rst = 1'b1; rgb_busy = 1'b1; pix_wr = 1'b1; pix_data = 24'hDEAD01; start = 1'b1; frame_len = 16'd4;
    exp_q.delete();
    tick();
    rst = 1'b0; rgb_busy = 1'b0; pix_wr = 1'b0; start = 1'b0;
    chk("rst_vld",    {31'd0, rgb_vld},  32'd0);
    chk("rst_active", {31'd0, active},   32'd0);
    chk("rst_full",   {31'd0, pix_full}, 32'd0);
    chk("rst_done",   {31'd0, done},     32'd0);
    write_pix(24'hAABBCC, 1);
    start_frame(16'd1);
    chk("rst_new_pixel", {8'd0, rgb_data}, 32'hAABBCC);
    wait_done("rst_new_done", 10);
    tick();

    // Full FIFO, push and pop in the same cycle: push dropped
    write_pix(24'h0A0A0A, 1);
    write_pix(24'h0B0B0B, 1);
    write_pix(24'h0C0C0C, 1);
    write_pix(24'h0D0D0D, 1);
    rgb_busy = 1'b1;
    start_frame(16'd1);
    chk("pp_full", {31'd0, pix_full}, 32'd1);
    rgb_busy = 1'b0;
    write_pix(24'hEEEEEE, 0);
    chk("pp_done", {31'd0, done}, 32'd1);
    chk("pp_occupancy_below_full", {31'd0, pix_full}, 32'd0);
    tick();
    write_pix(24'h0F0F0F, 1);
    chk("pp_full_again", {31'd0, pix_full}, 32'd1);
    start_frame(16'd4);
    wait_done("pp_frame2_done", 20);
    tick();

    // SEND with empty FIFO: vld one cycle after the write
    start_frame(16'd2);
    chk("lat_active",   {31'd0, active},  32'd1);
    chk("lat_vld_none", {31'd0, rgb_vld}, 32'd0);
    write_pix(24'h123456, 1);
    chk("lat_vld_next", {31'd0, rgb_vld}, 32'd1);
    write_pix(24'h654321, 1);
    wait_done("lat_done", 10);
    tick();
    tick();

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_p2p_tx.md
RGB_P2P_TX -- requirements
Module: rgb_p2p_tx

Interface
REQ-001 Parameter: DATA_W, default 24, pixel width (packed R/G/B, 8 bits each).
REQ-002 Parameter: DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-003 Parameter: LEN_W, default 16, frame-length counter width.
REQ-004 Port: i_clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: i_rst  in  1  synchronous, active-high reset.
REQ-006 Port: i_pix_wr  in  1  upstream pixel write strobe.
REQ-007 Port: i_pix_data  in  DATA_W  upstream pixel.
REQ-008 Port: o_pix_full  out  1  FIFO holds DEPTH entries.
REQ-009 Port: i_start  in  1  frame start request.
REQ-010 Port: i_frame_len  in  LEN_W  pixels in the frame, sampled on accepted i_start.
REQ-011 Port: o_active  out  1  high in state SEND.
REQ-012 Port: o_done  out  1  one-cycle pulse at frame end.
REQ-013 Port: o_rgb_vld  out  1  p2p valid toward the filter's i_rgb input.
REQ-014 Port: o_rgb_data  out  DATA_W  p2p data.
REQ-015 Port: i_rgb_busy  in  1  p2p busy from the filter.

Function
REQ-016 Transfer occurs on a rising edge when o_rgb_vld=1 and i_rgb_busy=0; no other condition.
REQ-017 o_rgb_vld = (state==SEND) and FIFO not empty; o_rgb_data = FIFO head, both from registers and FIFO state (no combinational path from i_rgb_busy).
REQ-018 While o_rgb_vld=1 and i_rgb_busy=1, o_rgb_data shall hold stable.
REQ-019 In IDLE and DONE, o_rgb_data shall be 0.
REQ-020 FIFO write: i_pix_wr=1 and o_pix_full=0 pushes i_pix_data; write while full is dropped, even if a transfer pops the same cycle.
REQ-021 Simultaneous push and pop when not full: both occur, occupancy unchanged.
REQ-022 FIFO accepts writes in every state; pixels preloaded in IDLE are sent first when SEND begins.
REQ-023 Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-024 States: IDLE, SEND, DONE.
REQ-025 IDLE: i_start=1, i_frame_len!=0 -> latch remaining=i_frame_len, go SEND; i_start=1, i_frame_len==0 -> go DONE directly.
REQ-026 SEND: each transfer decrements remaining; the transfer with remaining==1 -> DONE.
REQ-027 DONE: o_done=1 for exactly one cycle, o_rgb_vld=0, next IDLE.
REQ-028 i_start in SEND or DONE is ignored.
REQ-029 Latency: pixel written into empty FIFO during SEND drives o_rgb_vld on the next cycle; i_start with non-empty FIFO gives o_rgb_vld on the next cycle.
REQ-030 Excess FIFO pixels after DONE remain queued for the next frame.

Reset
REQ-031 i_rst=1 at any edge, including mid-frame: state IDLE, FIFO flushed, remaining=0; o_rgb_vld=0, o_rgb_data=0, o_pix_full=0, o_active=0, o_done=0 on the following cycle.
REQ-032 Writes and starts during the reset cycle are discarded.

Structure
REQ-033 State enum and default DATA_W/LEN_W constants belong in the shared filter package used by the DC filter flow.
REQ-034 FIFO is one sub-module, rgb_sync_fifo (push/pop/full/empty/head); FSM and counter stay in rgb_p2p_tx.

Verification
REQ-035 Preload 3 pixels 0x102030,0x405060,0x708090; start len=3, busy=0 -> three transfers on consecutive cycles in order, o_done pulses the cycle after the third.
REQ-036 len=2, busy held 1 for 5 cycles after vld rises -> o_rgb_data stays 0x102030 for all 5 cycles, transfer on first busy=0 edge.
REQ-037 Write 5 pixels back-to-back into empty FIFO in IDLE (DEPTH=4) -> o_pix_full high after 4th, 5th dropped, later frame len=4 sends first four only.
REQ-038 start with len=0 -> no vld, o_done pulses next cycle, back to IDLE.
REQ-039 i_rst asserted after 2 of 4 transfers -> next cycle vld=0, FIFO empty, o_active=0; new start len=1 with one new pixel sends only that pixel.
REQ-040 Full FIFO, push and pop same cycle -> push dropped, occupancy becomes DEPTH-1.
